// File: rtl/pc_ir_unit_pkg.sv
// Shared CPU definitions for the fetch stage and the control unit.
//   pc_sel_t      : PC select encoding driven by the control unit
//   BR_OFS_W      : width of the relative-branch offset field
//   br_ofs_field  : gathers the split offset field {ins[8:6], ins[2:0]}
package pc_ir_unit_pkg;

  typedef enum logic [1:0] {
    PC_HOLD = 2'b00,
    PC_INC  = 2'b01,
    PC_BR   = 2'b10,
    PC_JMP  = 2'b11
  } pc_sel_t;

  localparam int BR_OFS_W = 6;

  // The offset is split across the instruction word: high half in [8:6],
  // low half in [2:0]. Only the low nine bits of the word are needed.
  function automatic logic [BR_OFS_W-1:0] br_ofs_field(input logic [8:0] ins_lo);
    return {ins_lo[8:6], ins_lo[2:0]};
  endfunction

endpackage

// File: rtl/pc_ir_unit_pc_next.sv
// Next-PC selection (purely combinational).
//   pc     in  ADDR_W  current PC
//   ps     in  2       PC select (hold / increment / relative branch / jump)
//   ir     in  DATA_W  instruction register, source of the branch offset
//   a      in  ADDR_W  jump target
//   pc_nxt out ADDR_W  PC for the next cycle, modulo 2^ADDR_W
module pc_next
  import pc_ir_unit_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] pc,
  input  pc_sel_t           ps,
  input  logic [DATA_W-1:0] ir,
  input  logic [ADDR_W-1:0] a,
  output logic [ADDR_W-1:0] pc_nxt
);

  logic [BR_OFS_W-1:0] ofs;
  logic [ADDR_W-1:0]   ofs_sext;

  assign ofs      = br_ofs_field(ir[8:0]);
  // Two's-complement add of the sign-extended offset gives the modulo wrap.
  assign ofs_sext = {{(ADDR_W-BR_OFS_W){ofs[BR_OFS_W-1]}}, ofs};

  // Only the offset bits of the instruction matter here.
  wire unused_ir_hi = ^ir[DATA_W-1:9];

  always_comb begin
    pc_nxt = pc;
    case (ps)
      PC_HOLD: pc_nxt = pc;
      PC_INC:  pc_nxt = pc + ADDR_W'(1);
      PC_BR:   pc_nxt = pc + ofs_sext;
      PC_JMP:  pc_nxt = a;
      default: pc_nxt = pc;
    endcase
  end

endmodule

// File: rtl/pc_ir_unit.sv
// Program counter / instruction register stage with debug counters.
//   clk           in  1       system clock
//   rst_n         in  1       asynchronous active-low reset
//   ps_in         in  2       PC select from control unit
//   il_in         in  1       instruction load from control unit
//   ins_mem_in    in  DATA_W  instruction memory data at pc_out
//   a_in          in  DATA_W  register-file A bus (jump target)
//   pc_out        out ADDR_W  current PC / instruction address
//   ins_out       out DATA_W  instruction register
//   br_taken_out  out 1       pulse: last edge branched or jumped
//   fetch_cnt_out out CNT_W   IR loads since reset
//   br_cnt_out    out CNT_W   branch/jump PC updates since reset
module pc_ir_unit
  import pc_ir_unit_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int RESET_PC = 0,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        ps_in,
  input  logic              il_in,
  input  logic [DATA_W-1:0] ins_mem_in,
  input  logic [DATA_W-1:0] a_in,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] ins_out,
  output logic              br_taken_out,
  output logic [CNT_W-1:0]  fetch_cnt_out,
  output logic [CNT_W-1:0]  br_cnt_out
);

  pc_sel_t           ps_sel;
  logic              is_br;
  logic [ADDR_W-1:0] pc_reg, pc_next_val;
  logic [DATA_W-1:0] ir_reg;
  logic              br_taken_reg;
  logic [CNT_W-1:0]  fetch_cnt_reg, br_cnt_reg;

  assign ps_sel = pc_sel_t'(ps_in);
  // Both relative branch and jump count as a taken branch, even when the
  // resulting PC equals the current one.
  assign is_br  = (ps_sel == PC_BR) || (ps_sel == PC_JMP);

  // The offset comes from the IR as it stands before this edge, so a
  // simultaneous IR load cannot influence the branch target.
  pc_next #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_pc_next (
    .pc     (pc_reg),
    .ps     (ps_sel),
    .ir     (ir_reg),
    .a      (a_in[ADDR_W-1:0]),
    .pc_nxt (pc_next_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg        <= ADDR_W'(RESET_PC);
      ir_reg        <= '0;
      br_taken_reg  <= 1'b0;
      fetch_cnt_reg <= '0;
      br_cnt_reg    <= '0;
    end else begin
      pc_reg       <= pc_next_val;
      br_taken_reg <= is_br;
      if (is_br) begin
        br_cnt_reg <= br_cnt_reg + CNT_W'(1);
      end
      if (il_in) begin
        ir_reg        <= ins_mem_in;
        fetch_cnt_reg <= fetch_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign pc_out        = pc_reg;
  assign ins_out       = ir_reg;
  assign br_taken_out  = br_taken_reg;
  assign fetch_cnt_out = fetch_cnt_reg;
  assign br_cnt_out    = br_cnt_reg;

`ifndef SYNTHESIS
  // Control inputs must be driven whenever the stage is out of reset.
  assert property (@(posedge clk) disable iff (!rst_n) !$isunknown({ps_in, il_in}))
    else $error("pc_ir_unit: ps_in/il_in unknown at clock edge");

  // A jump target wider than the PC silently loses its upper bits.
  generate
    if (DATA_W > ADDR_W) begin : g_jmp_range
      assert property (@(posedge clk) disable iff (!rst_n)
                       (ps_sel == PC_JMP) |-> (a_in[DATA_W-1:ADDR_W] == '0))
        else $warning("pc_ir_unit: jump target has nonzero bits above ADDR_W");
    end
  endgenerate
`endif

endmodule

// File: tb/tb_pc_ir_unit.sv
module tb_pc_ir_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  ps_in = 2'b00;
  logic        il_in = 1'b0;
  logic [15:0] ins_mem_in = '0;
  logic [15:0] a_in = '0;
  logic [15:0] pc_out;
  logic [15:0] ins_out;
  logic        br_taken_out;
  logic [31:0] fetch_cnt_out;
  logic [31:0] br_cnt_out;

  pc_ir_unit #(
    .DATA_W   (16),
    .ADDR_W   (16),
    .RESET_PC (0),
    .CNT_W    (32)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ps_in         (ps_in),
    .il_in         (il_in),
    .ins_mem_in    (ins_mem_in),
    .a_in          (a_in),
    .pc_out        (pc_out),
    .ins_out       (ins_out),
    .br_taken_out  (br_taken_out),
    .fetch_cnt_out (fetch_cnt_out),
    .br_cnt_out    (br_cnt_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          pc;
    int          ins;
    int          bt;
    int unsigned fc;
    int unsigned bc;
  } exp_t;

  exp_t exp_q[$];

  int n_pass  = 0;
  int n_total = 0;
  int n_txn   = 0;

  // Reference model state, plain integers.
  int          m_pc, m_ir, m_bt;
  int unsigned m_fc, m_bc;

  function automatic void chk(string name, longint act, longint expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
  endfunction

  function automatic int sext_ofs(int ir);
    int f;
    f = (((ir >> 6) & 7) << 3) | (ir & 7);
    return (f >= 32) ? f - 64 : f;
  endfunction

  function automatic void model_reset();
    m_pc = 0; m_ir = 0; m_bt = 0; m_fc = 0; m_bc = 0;
  endfunction

  function automatic exp_t model_snapshot();
    exp_t e;
    e.pc = m_pc; e.ins = m_ir; e.bt = m_bt; e.fc = m_fc; e.bc = m_bc;
    return e;
  endfunction

  // One cycle of stimulus: drive between edges, advance model, queue result.
  task automatic step(input int ps, input int il, input int ins, input int a);
    int ofs;
    @(negedge clk);
    ps_in      = ps[1:0];
    il_in      = il[0];
    ins_mem_in = ins[15:0];
    a_in       = a[15:0];
    ofs = sext_ofs(m_ir);
    case (ps)
      1: m_pc = (m_pc + 1) % 65536;
      2: m_pc = (m_pc + 65536 + ofs) % 65536;
      3: m_pc = a % 65536;
      default: ;
    endcase
    m_bt = (ps >= 2) ? 1 : 0;
    if (ps >= 2) m_bc++;
    if (il != 0) begin
      m_ir = ins % 65536;
      m_fc++;
    end
    exp_q.push_back(model_snapshot());
  endtask

  function automatic void check_outputs(string tag, exp_t e);
    chk({tag, ".pc"},  pc_out,        e.pc);
    chk({tag, ".ins"}, ins_out,       e.ins);
    chk({tag, ".bt"},  br_taken_out,  e.bt);
    chk({tag, ".fc"},  fetch_cnt_out, e.fc);
    chk({tag, ".bc"},  br_cnt_out,    e.bc);
  endfunction

  // Monitor: every clock edge with a pending expectation is one transaction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_txn++;
        check_outputs("txn", e);
        $display("txn %0d pc=%04h ins=%04h bt=%0d fc=%0d bc=%0d",
                 n_txn, pc_out, ins_out, br_taken_out, fetch_cnt_out, br_cnt_out);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #12;
    check_outputs("reset", model_snapshot());
    $display("reset check pc=%04h ins=%04h", pc_out, ins_out);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: sequential increments
    repeat (3) step(1, 0, 0, 0);

    // 2: branch by -1 from 0x0010
    step(3, 1, 16'hC1C7, 16'h0010);
    step(2, 0, 0, 0);
    step(0, 0, 0, 0);

    // 3: branch by +31, then jump
    step(3, 1, 16'h00C7, 16'h0010);
    step(2, 0, 0, 0);
    step(3, 0, 0, 16'h1234);

    // 4: increment wrap and negative wrap
    step(3, 0, 0, 16'hFFFF);
    step(1, 0, 0, 0);
    step(3, 1, 16'h0100, 16'h0002);
    step(2, 0, 0, 0);

    // 5: IR load and branch on the same edge use the old IR
    step(3, 1, 16'h0004, 16'h0008);
    step(2, 1, 16'hAAAA, 0);

    // Halt: state must hold
    repeat (3) step(0, 0, $urandom_range(0, 65535), $urandom_range(0, 65535));

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3), $urandom_range(0, 1),
           $urandom_range(0, 65535), $urandom_range(0, 65535));
    end

    // 6: asynchronous reset between edges
    repeat (5) step(1, 1, $urandom_range(0, 65535), 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    ps_in = 2'b00;
    il_in = 1'b0;
    #1;
    model_reset();
    check_outputs("async_reset", model_snapshot());
    $display("async reset check pc=%04h fc=%0d", pc_out, fetch_cnt_out);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, 16'h5A5A, 0);
    step(1, 0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d transactions pending, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
